router_dest_reader: RTL and testbench

- Destination-side consumer for one output port of the 1x3 router.
- Watches the port's valid_out and drives read_enb with a programmable start delay, so the bench can exercise both normal drain and the router's 30-cycle soft-reset timeout.
- Pulls header, payload and parity bytes from the port FIFO, checks the parity byte and the address field, and reports per-packet status plus running counters.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_parity_acc.sv | 28 ++
 rtl/router_dest_reader.sv | 154 +++++++++++++++
 tb/tb_router_dest_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared widths, timing constants and reader FSM states for the router
// destination-side blocks.
package router_pkg;

  localparam int unsigned HDR_ADDR_W  = 2;
  localparam int unsigned HDR_LEN_W   = 6;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned TIMEOUT_CYC = 30;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HDR,
    BODY,
    DONE
  } rd_state_e;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity register: clear, load with the header, accumulate payload,
// and compare against an incoming parity byte.
module router_parity_acc
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              acc,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] par,
  output logic              match
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      par <= '0;
    end else if (load) begin
      par <= din;
    end else if (acc) begin
      par <= par ^ din;
    end
  end

  assign match = (par == din);

endmodule

// File: rtl/router_dest_reader.sv
// Destination-side reader for one router output port: delayed start, header
// decode, payload drain with parity/address checks, abort on soft reset.
module router_dest_reader
  import router_pkg::*;
#(
  parameter logic [HDR_ADDR_W-1:0] PORT_ADDR = 2'b00,
  parameter int unsigned           TIMEOUT   = TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_out,
  input  logic [BYTE_W-1:0]    dout,
  input  logic                 soft_rst,
  input  logic [4:0]           start_delay,
  output logic                 read_enb,
  output logic                 pkt_done,
  output logic                 pkt_ok,
  output logic                 err_parity,
  output logic                 err_addr,
  output logic                 err_abort,
  output logic [HDR_LEN_W-1:0] rx_len,
  output logic [15:0]          pkt_count,
  output logic [15:0]          err_count
);

  rd_state_e         state, state_n;
  logic [4:0]        dly_cnt;
  logic [4:0]        dly_init;
  logic              hdr_issued;
  logic [HDR_LEN_W:0] req_left;
  logic [HDR_LEN_W:0] rcv_left;
  logic [HDR_LEN_W:0] hdr_total;
  logic              rd_q;
  logic              err_par_q;
  logic              err_addr_q;
  logic              abort;
  logic              par_load;
  logic              par_acc;
  logic [BYTE_W-1:0] par;
  logic              par_match;

  // Waiting past TIMEOUT is pointless (the router flushes the port first), so
  // the delay is clamped; observable behaviour is unchanged.
  assign dly_init  = (32'(start_delay) > TIMEOUT) ? 5'(TIMEOUT) : start_delay;
  assign hdr_total = {1'b0, dout[BYTE_W-1:HDR_ADDR_W]} + 1'b1;

  router_parity_acc u_par (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .load  (par_load),
    .acc   (par_acc),
    .din   (dout),
    .par   (par),
    .match (par_match)
  );

  always_comb begin
    state_n  = state;
    read_enb = 1'b0;
    abort    = 1'b0;
    par_load = 1'b0;
    par_acc  = 1'b0;
    unique case (state)
      IDLE: if (vld_out) state_n = WAIT;
      WAIT: if (dly_cnt == '0) state_n = HDR;
      HDR: begin
        read_enb = vld_out && !hdr_issued;
        if (rd_q) begin
          par_load = 1'b1;
          state_n  = BODY;
        end
      end
      BODY: begin
        read_enb = vld_out && (req_left != '0);
        if (rd_q) begin
          if (rcv_left == 7'd1) state_n = DONE;
          else                  par_acc = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Soft reset overrides everything outside IDLE, including the read strobe.
    if (soft_rst && (state != IDLE)) begin
      read_enb = 1'b0;
      abort    = 1'b1;
      par_load = 1'b0;
      par_acc  = 1'b0;
      state_n  = IDLE;
    end
  end

  assign pkt_done   = (state == DONE) && !soft_rst;
  assign err_parity = pkt_done && err_par_q;
  assign err_addr   = pkt_done && err_addr_q;
  assign pkt_ok     = pkt_done && !err_par_q && !err_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      hdr_issued <= 1'b0;
      req_left   <= '0;
      rcv_left   <= '0;
      rd_q       <= 1'b0;
      err_par_q  <= 1'b0;
      err_addr_q <= 1'b0;
      err_abort  <= 1'b0;
      rx_len     <= '0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      state     <= state_n;
      rd_q      <= read_enb;
      err_abort <= abort;
      if (abort) begin
        err_count <= err_count + 16'd1;
      end else begin
        unique case (state)
          IDLE: begin
            dly_cnt    <= dly_init;
            hdr_issued <= 1'b0;
            err_par_q  <= 1'b0;
            err_addr_q <= 1'b0;
          end
          WAIT: if (dly_cnt != '0) dly_cnt <= dly_cnt - 5'd1;
          HDR: begin
            if (read_enb) hdr_issued <= 1'b1;
            if (rd_q) begin
              rx_len     <= dout[BYTE_W-1:HDR_ADDR_W];
              req_left   <= hdr_total;
              rcv_left   <= hdr_total;
              err_addr_q <= (dout[HDR_ADDR_W-1:0] != PORT_ADDR);
            end
          end
          BODY: begin
            if (read_enb) req_left <= req_left - 7'd1;
            if (rd_q) begin
              rcv_left <= rcv_left - 7'd1;
              if (rcv_left == 7'd1) err_par_q <= !par_match;
            end
          end
          DONE: begin
            if (pkt_ok) pkt_count <= pkt_count + 16'd1;
            else        err_count <= err_count + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_dest_reader.sv
// Scoreboard bench for router_dest_reader: a router-port model feeds packets,
// a monitor checks each pkt_done / err_abort event against queued expectations.
module tb_router_dest_reader;
  import router_pkg::*;

  localparam logic [1:0] PORT = 2'b00;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_out;
  logic [7:0]  dout;
  logic        soft_rst;
  logic [4:0]  start_delay;
  logic        read_enb, pkt_done, pkt_ok, err_parity, err_addr, err_abort;
  logic [5:0]  rx_len;
  logic [15:0] pkt_count, err_count;

  router_dest_reader #(.PORT_ADDR(PORT), .TIMEOUT(30)) dut (
    .clk(clk), .rst(rst), .vld_out(vld_out), .dout(dout), .soft_rst(soft_rst),
    .start_delay(start_delay), .read_enb(read_enb), .pkt_done(pkt_done),
    .pkt_ok(pkt_ok), .err_parity(err_parity), .err_addr(err_addr),
    .err_abort(err_abort), .rx_len(rx_len), .pkt_count(pkt_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          abort;
    bit          ok;
    bit          ep;
    bit          ea;
    logic [5:0]  len;
    logic [15:0] pc;
    logic [15:0] ec;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fifo[$];
  logic [7:0] pl[64];
  int tests = 0;
  int fails = 0;
  int mpc = 0;
  int mec = 0;
  int reads = 0;
  int pause_at = -1;
  int pause_cnt = 0;
  int idle_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Router port model: FIFO with registered read data and idle-timeout flush.
  initial begin
    bit rd, fire, clr;
    vld_out  = 1'b0;
    soft_rst = 1'b0;
    dout     = '0;
    forever begin
      @(negedge clk);
      rd   = read_enb;
      clr  = rst;
      fire = 1'b0;
      if (rd) check("rd_needs_vld", 32'(vld_out), 32'd1);
      if (soft_rst) check("rd_gated_by_softrst", 32'(read_enb), 32'd0);
      if (vld_out && !rd && !soft_rst && !rst) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt >= int'(TIMEOUT_CYC)) begin
        fire     = 1'b1;
        idle_cnt = 0;
      end
      @(posedge clk);
      #1;
      if (pause_cnt > 0) pause_cnt--;
      if (rd && fifo.size() > 0) begin
        dout = fifo.pop_front();
        reads++;
        if (reads == pause_at) pause_cnt = 4;
      end
      if (fire || clr) begin
        fifo.delete();
        pause_cnt = 0;
      end
      soft_rst = fire;
      vld_out  = (fifo.size() > 0) && (pause_cnt == 0);
    end
  end

  // Monitor: pops an expectation per event, checks counters one cycle later.
  initial begin
    bit   chk_cnt;
    exp_t e, last;
    chk_cnt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk_cnt = 1'b0;
        continue;
      end
      if (chk_cnt) begin
        check("pkt_count", 32'(pkt_count), 32'(last.pc));
        check("err_count", 32'(err_count), 32'(last.ec));
        chk_cnt = 1'b0;
      end
      if (pkt_done || err_abort) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: done=%0b abort=%0b with nothing expected", pkt_done, err_abort);
        end else begin
          e = sb.pop_front();
          check("err_abort", 32'(err_abort), 32'(e.abort));
          check("pkt_done", 32'(pkt_done), 32'(!e.abort));
          if (!e.abort) begin
            check("pkt_ok", 32'(pkt_ok), 32'(e.ok));
            check("err_parity", 32'(err_parity), 32'(e.ep));
            check("err_addr", 32'(err_addr), 32'(e.ea));
            check("rx_len", 32'(rx_len), 32'(e.len));
          end
          last    = e;
          chk_cnt = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] hdr, input logic [7:0] flip, input logic [4:0] dly,
                      input int pause, input bit exp_abort, input bit drain);
    exp_t       e;
    logic [7:0] p;
    int         len, n;
    len = int'(hdr[7:2]);
    p   = hdr;
    for (int i = 0; i < len; i++) p ^= pl[i];
    @(posedge clk);
    start_delay = dly;
    reads       = 0;
    pause_at    = pause;
    e.abort = exp_abort;
    e.ep    = (flip != 8'h00);
    e.ea    = (hdr[1:0] != PORT);
    e.ok    = !e.ep && !e.ea;
    e.len   = hdr[7:2];
    if (!exp_abort && e.ok) mpc++;
    else mec++;
    e.pc = 16'(mpc);
    e.ec = 16'(mec);
    sb.push_back(e);
    fifo.push_back(hdr);
    for (int i = 0; i < len; i++) fifo.push_back(pl[i]);
    fifo.push_back(p ^ flip);
    if (drain) begin
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
        @(posedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d events still pending after %0d cycles", sb.size(), n);
        sb.delete();
        fifo.delete();
      end
      check("read_strobes", 32'(reads), exp_abort ? 32'd0 : 32'(len + 2));
      repeat (3) @(posedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_enb"}, 32'(read_enb), 32'd0);
    check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
    check({tag, "_pkt_ok"}, 32'(pkt_ok), 32'd0);
    check({tag, "_err_parity"}, 32'(err_parity), 32'd0);
    check({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    check({tag, "_err_abort"}, 32'(err_abort), 32'd0);
    check({tag, "_rx_len"}, 32'(rx_len), 32'd0);
    check({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    logic [7:0] hdr, flip;
    int         n;
    rst         = 1'b1;
    start_delay = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send(8'h0C, 8'h00, 5'd0, -1, 1'b0, 1'b1);
    send(8'h0C, 8'h01, 5'd0, -1, 1'b0, 1'b1);
    send(8'h0D, 8'h00, 5'd3, -1, 1'b0, 1'b1);
    send(8'h0C, 8'h00, 5'd2, 2, 1'b0, 1'b1);
    send(8'h0C, 8'h00, 5'd31, -1, 1'b1, 1'b1);
    send(8'h00, 8'h00, 5'd1, -1, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
      hdr[7:2] = (k == 7) ? 6'd63 : 6'($urandom_range(0, 15));
      hdr[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : PORT;
      flip     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send(hdr, flip, 5'($urandom_range(0, 20)),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : -1, 1'b0, 1'b1);
    end
    send(8'h0F, 8'h00, 5'd30, -1, 1'b1, 1'b1);

    // Reset in the middle of a 3-byte-payload packet.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send(8'h0C, 8'h00, 5'd0, -1, 1'b0, 1'b0);
    n = 0;
    while (reads < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("reads_before_rst", 32'(reads >= 2), 32'd1);
    #2 rst = 1'b1;
    sb.delete();
    mpc = 0;
    mec = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    send(8'h0C, 8'h00, 5'd0, -1, 1'b0, 1'b1);
    check("final_pkt_count", 32'(pkt_count), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
